// File: rtl/fp16_pkg.sv
// Shared fp16 result definitions: word type, one-hot type bit indices and sticky flag indices.
package fp16_pkg;

   localparam int unsigned FP16_W = 16;
   localparam int unsigned TYPE_W = 6;
   localparam int unsigned FLAG_W = 6;

   typedef logic [FP16_W-1:0] fp16_t;

   localparam int unsigned TYPE_NAN0 = 0;
   localparam int unsigned TYPE_NAN1 = 1;
   localparam int unsigned TYPE_INF  = 2;
   localparam int unsigned TYPE_ZERO = 3;
   localparam int unsigned TYPE_SUBN = 4;
   localparam int unsigned TYPE_NORM = 5;

   localparam int unsigned FLAG_NAN      = 0;
   localparam int unsigned FLAG_INF      = 1;
   localparam int unsigned FLAG_UNF      = 2;
   localparam int unsigned FLAG_ZERO     = 3;
   localparam int unsigned FLAG_DROP     = 4;
   localparam int unsigned FLAG_TYPE_ERR = 5;

   localparam logic [TYPE_W-1:0] TYPE_SUBN_OH = 6'b010000;
   localparam logic [TYPE_W-1:0] TYPE_ZERO_OH = 6'b001000;

   typedef struct packed {
      fp16_t             data;
      logic [TYPE_W-1:0] typ;
   } drain_word_t;

   function automatic logic is_onehot(input logic [TYPE_W-1:0] t);
      return (t != '0) && ((t & (t - TYPE_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/sa_drain_fifo.sv
// Generic synchronous FIFO with registered show-ahead head, valid, full and level.
module sa_drain_fifo #(
   parameter int unsigned WIDTH = 22,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, lvl_q, lvl_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             valid_q, valid_d, full_q, full_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && valid_q;
   assign do_push = push_i && (!full_q || do_pop);

   // Head register follows the next read pointer; bypass when that slot is being written now.
   always_comb begin
      wr_d    = wr_q + PW'(do_push);
      rd_d    = rd_q + PW'(do_pop);
      lvl_d   = wr_d - rd_d;
      valid_d = (wr_d != rd_d);
      full_d  = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);
      rdata_d = rdata_q;
      if (valid_d) begin
         if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) rdata_d = wdata_i;
         else                                            rdata_d = mem_q[rd_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         lvl_q   <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         lvl_q   <= lvl_d;
         valid_q <= valid_d;
         full_q  <= full_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage array carries no reset; only the pointers define occupancy.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = rdata_q;
   assign valid_o = valid_q;
   assign full_o  = full_q;
   assign level_o = lvl_q;

endmodule

// File: rtl/sa_result_drain.sv
// SA column result drain: FIFO capture of fp16 results, sticky flags and saturating drop counter.
// Optional SA_DRAIN_FTZ_EN flushes subnormals to signed zero on push.
module sa_result_drain
   import fp16_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    DVI,
   input  logic [15:0]             DI,
   input  logic [5:0]              DI_TYPE,
   output logic                    DO_VALID,
   input  logic                    DO_READY,
   output logic [15:0]             DO,
   output logic [5:0]              DO_TYPE,
   output logic [$clog2(DEPTH):0]  LEVEL,
   input  logic                    CLR_FLAGS,
   output logic [5:0]              FLAGS,
   output logic [CNT_W-1:0]        DROP_CNT
);

   localparam int unsigned WORD_W = $bits(drain_word_t);

   drain_word_t        wr_word, head;
   logic [WORD_W-1:0]  head_raw;
   logic               full, pop, push, drop;
   logic [FLAG_W-1:0]  flags_q, flags_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign pop  = DO_VALID && DO_READY;
   assign push = DVI && (!full || pop);
   assign drop = DVI && full && !pop;

   always_comb begin
      wr_word.data = DI;
      wr_word.typ  = DI_TYPE;
`ifdef SA_DRAIN_FTZ_EN
      if (DI_TYPE == TYPE_SUBN_OH) begin
         wr_word.data = {DI[15], 15'h0};
         wr_word.typ  = TYPE_ZERO_OH;
      end
`endif
   end

   sa_drain_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_word),
      .rdata_o (head_raw),
      .valid_o (DO_VALID),
      .full_o  (full),
      .level_o (LEVEL)
   );

   assign head    = drain_word_t'(head_raw);
   assign DO      = head.data;
   assign DO_TYPE = head.typ;

   // Clear first, then OR in this cycle's events so a coincident event survives the clear.
   always_comb begin
      flags_d = CLR_FLAGS ? '0 : flags_q;
      cnt_d   = CLR_FLAGS ? '0 : cnt_q;
      if (DVI) begin
         if (DI_TYPE[TYPE_NAN0] || DI_TYPE[TYPE_NAN1]) flags_d[FLAG_NAN] = 1'b1;
         if (DI_TYPE[TYPE_INF])  flags_d[FLAG_INF]  = 1'b1;
         if (DI_TYPE[TYPE_SUBN]) flags_d[FLAG_UNF]  = 1'b1;
         if (DI_TYPE[TYPE_ZERO]) flags_d[FLAG_ZERO] = 1'b1;
         if (!is_onehot(DI_TYPE)) flags_d[FLAG_TYPE_ERR] = 1'b1;
      end
      if (drop) begin
         flags_d[FLAG_DROP] = 1'b1;
         if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         flags_q <= '0;
         cnt_q   <= '0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign FLAGS    = flags_q;
   assign DROP_CNT = cnt_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain; honours SA_DRAIN_FTZ_EN when defined.
module tb_sa_result_drain;
   import fp16_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 8;
   localparam logic [5:0]  T_NORM = 6'b100000;
   localparam logic [5:0]  T_INF  = 6'b000100;
   localparam logic [5:0]  T_NAN0 = 6'b000001;
   localparam logic [5:0]  T_SUBN = 6'b010000;
   localparam logic [5:0]  T_ZERO = 6'b001000;

   logic                   CLK = 1'b0;
   logic                   RST = 1'b1;
   logic                   DVI = 1'b0;
   logic [15:0]            DI = '0;
   logic [5:0]             DI_TYPE = '0;
   logic                   DO_VALID;
   logic                   DO_READY = 1'b0;
   logic [15:0]            DO;
   logic [5:0]             DO_TYPE;
   logic [$clog2(DEPTH):0] LEVEL;
   logic                   CLR_FLAGS = 1'b0;
   logic [5:0]             FLAGS;
   logic [CNT_W-1:0]       DROP_CNT;

   int n_tests = 0;
   int n_fail  = 0;
   int n_popped = 0;
   logic [21:0] sb_q[$];

   sa_result_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .DVI(DVI), .DI(DI), .DI_TYPE(DI_TYPE),
      .DO_VALID(DO_VALID), .DO_READY(DO_READY), .DO(DO), .DO_TYPE(DO_TYPE),
      .LEVEL(LEVEL), .CLR_FLAGS(CLR_FLAGS), .FLAGS(FLAGS), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: compare head on accept, then enqueue the expected stored word.
   always @(negedge CLK) begin
      logic [21:0] exp_w, head_w;
      if (RST) begin
         sb_q.delete();
      end else begin
         n_tests++;
         if (DO_VALID !== (sb_q.size() != 0) || LEVEL !== 4'(sb_q.size())) begin
            n_fail++;
            $display("FAIL sb_state: DO_VALID=%b LEVEL=%0d, need valid=%b level=%0d",
                     DO_VALID, LEVEL, sb_q.size() != 0, sb_q.size());
         end
         if (sb_q.size() != 0 && DO_READY) begin
            exp_w  = sb_q.pop_front();
            head_w = {DO, DO_TYPE};
            n_popped++;
            n_tests++;
            if (head_w !== exp_w) begin
               n_fail++;
               $display("FAIL sb_data: got %h/%b, need %h/%b", DO, DO_TYPE, exp_w[21:6], exp_w[5:0]);
            end
         end
         if (DVI && sb_q.size() < DEPTH) begin
            exp_w = {DI, DI_TYPE};
`ifdef SA_DRAIN_FTZ_EN
            if (DI_TYPE == T_SUBN) exp_w = {DI[15], 15'h0, T_ZERO};
`endif
            sb_q.push_back(exp_w);
         end
      end
   end

   task automatic step(input logic dvi, input logic [15:0] d, input logic [5:0] t,
                       input logic rdy, input logic clr);
      DVI = dvi; DI = d; DI_TYPE = t; DO_READY = rdy; CLR_FLAGS = clr;
      @(posedge CLK);
      #1;
      DVI = 1'b0; DO_READY = 1'b0; CLR_FLAGS = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && DO_VALID; i++) step(1'b0, 16'h0, 6'h0, 1'b1, 1'b0);
      n_tests++;
      if (DO_VALID !== 1'b0 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: DO_VALID=%b sb=%0d, need 0/0", DO_VALID, sb_q.size());
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
      n_tests++;
      if ({DO_VALID, DO, DO_TYPE, LEVEL, FLAGS, DROP_CNT} !== '0) begin
         n_fail++;
         $display("FAIL reset: v=%b do=%h t=%b lvl=%0d fl=%b cnt=%0d, need all 0",
                  DO_VALID, DO, DO_TYPE, LEVEL, FLAGS, DROP_CNT);
      end
      RST = 1'b0;
   endtask

   task automatic test_single();
      step(1'b1, 16'h3C00, T_NORM, 1'b0, 1'b0);
      n_tests++;
      if (DO_VALID !== 1'b1 || DO !== 16'h3C00 || DO_TYPE !== T_NORM || LEVEL !== 4'd1) begin
         n_fail++;
         $display("FAIL single: v=%b do=%h t=%b lvl=%0d, need 1/3c00/100000/1", DO_VALID, DO, DO_TYPE, LEVEL);
      end
      drain();
      n_tests++;
      if (DO !== 16'h3C00 || DO_TYPE !== T_NORM) begin
         n_fail++;
         $display("FAIL hold_empty: do=%h t=%b, need 3c00/100000", DO, DO_TYPE);
      end
   endtask

   task automatic test_overflow();
      int p0;
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h1000 + 16'(i), T_NORM, 1'b0, 1'b0);
      n_tests++;
      if (LEVEL !== 4'd8 || DROP_CNT !== 8'd2 || FLAGS !== 6'b010000) begin
         n_fail++;
         $display("FAIL overflow: lvl=%0d cnt=%0d fl=%b, need 8/2/010000", LEVEL, DROP_CNT, FLAGS);
      end
      p0 = n_popped;
      drain();
      n_tests++;
      if (n_popped - p0 != 8) begin
         n_fail++;
         $display("FAIL overflow_count: popped %0d, need 8", n_popped - p0);
      end
   endtask

   task automatic test_full_pushpop();
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 16'h2000 + 16'(i), T_NORM, 1'b0, 1'b0);
      step(1'b1, 16'hAAAA, T_NORM, 1'b1, 1'b0);
      n_tests++;
      if (LEVEL !== 4'd8 || DROP_CNT !== 8'd0 || FLAGS[4] !== 1'b0 || DO !== 16'h2001) begin
         n_fail++;
         $display("FAIL full_pushpop: lvl=%0d cnt=%0d drop=%b do=%h, need 8/0/0/2001",
                  LEVEL, DROP_CNT, FLAGS[4], DO);
      end
      // Full plus CLR with a drop: counter restarts at exactly one.
      step(1'b1, 16'h5555, T_NORM, 1'b0, 1'b1);
      n_tests++;
      if (DROP_CNT !== 8'd1 || FLAGS !== 6'b010000) begin
         n_fail++;
         $display("FAIL clr_drop: cnt=%0d fl=%b, need 1/010000", DROP_CNT, FLAGS);
      end
      for (int i = 0; i < 260; i++) step(1'b1, 16'h5555, T_NORM, 1'b0, 1'b0);
      n_tests++;
      if (DROP_CNT !== 8'hFF) begin
         n_fail++;
         $display("FAIL drop_sat: cnt=%0d, need 255", DROP_CNT);
      end
      drain();
   endtask

   task automatic test_flags();
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b1);
      step(1'b1, 16'h7C00, T_INF,  1'b1, 1'b0);
      step(1'b1, 16'h7FFF, T_NAN0, 1'b1, 1'b0);
      step(1'b1, 16'h0001, T_SUBN, 1'b1, 1'b0);
      n_tests++;
      if (FLAGS !== 6'b000111) begin
         n_fail++;
         $display("FAIL flags_set: fl=%b, need 000111", FLAGS);
      end
      step(1'b1, 16'h0000, T_ZERO, 1'b1, 1'b1);
      n_tests++;
      if (FLAGS !== 6'b001000) begin
         n_fail++;
         $display("FAIL flags_clr_event: fl=%b, need 001000", FLAGS);
      end
      drain();
   endtask

   task automatic test_type_err();
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b1);
      step(1'b1, 16'h1234, 6'b000011, 1'b0, 1'b0);
      n_tests++;
      if (FLAGS[5] !== 1'b1 || DO !== 16'h1234 || DO_TYPE !== 6'b000011) begin
         n_fail++;
         $display("FAIL type_err: fl=%b do=%h t=%b, need fl[5]=1 1234/000011", FLAGS, DO, DO_TYPE);
      end
      drain();
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b1);
      step(1'b1, 16'h8001, T_SUBN, 1'b0, 1'b0);
      n_tests++;
`ifdef SA_DRAIN_FTZ_EN
      if (DO !== 16'h8000 || DO_TYPE !== T_ZERO || FLAGS !== 6'b000100) begin
         n_fail++;
         $display("FAIL ftz: do=%h t=%b fl=%b, need 8000/001000/000100", DO, DO_TYPE, FLAGS);
      end
`else
      if (DO !== 16'h8001 || DO_TYPE !== T_SUBN || FLAGS !== 6'b000100) begin
         n_fail++;
         $display("FAIL subn: do=%h t=%b fl=%b, need 8001/010000/000100", DO, DO_TYPE, FLAGS);
      end
`endif
      drain();
   endtask

   task automatic test_reset_wrap();
      for (int i = 0; i < 5; i++) step(1'b1, 16'h3000 + 16'(i), T_INF, 1'b0, 1'b0);
      n_tests++;
      if (LEVEL !== 4'd5 || FLAGS[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst: lvl=%0d fl=%b, need 5 with fl[1]=1", LEVEL, FLAGS);
      end
      RST = 1'b1;
      step(1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
      RST = 1'b0;
      n_tests++;
      if (DO_VALID !== 1'b0 || LEVEL !== '0 || FLAGS !== '0 || DROP_CNT !== '0 || DO !== '0) begin
         n_fail++;
         $display("FAIL mid_rst: v=%b lvl=%0d fl=%b cnt=%0d do=%h, need all 0",
                  DO_VALID, LEVEL, FLAGS, DROP_CNT, DO);
      end
      for (int i = 0; i < 3 * DEPTH; i++)
         step(1'b1, 16'h4000 + 16'(i), T_NORM, (i >= 2), 1'b0);
      for (int i = 0; i < 3 * DEPTH; i++)
         step(1'($urandom_range(0, 1)), 16'h6000 + 16'(i), T_NORM, 1'($urandom_range(0, 1)), 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_pushpop();
      test_flags();
      test_type_err();
      test_reset_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
